// File: rtl/dcache_axi_bridge.sv
// Data-cache to AXI4 bridge: line refills and single-beat reads become INCR read bursts,
// dirty-line write-backs become 8-beat INCR write bursts, on independent channels.
module dcache_axi_bridge #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rd_req,
    input  logic [2:0]               rd_type,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_rdy,
    output logic                     ret_valid,
    output logic [LINE_WORDS*32-1:0] ret_data,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [3:0]               wr_wstrb,
    input  logic [LINE_WORDS*32-1:0] wr_data,
    output logic                     wr_rdy,
    output logic [ADDR_W-1:0]        araddr,
    output logic [7:0]               arlen,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [31:0]              rdata,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [ADDR_W-1:0]        awaddr,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic                     bvalid,
    output logic                     bready
);
    localparam int               OFF_W     = $clog2(LINE_WORDS * 4);
    localparam int               CNT_W     = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [7:0]       LINE_LEN  = 8'(LINE_WORDS - 1);
    localparam logic [2:0]       RD_LINE   = 3'b100;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

    r_state_t          r_state_q, r_state_d;
    w_state_t          w_state_q, w_state_d;
    logic [ADDR_W-1:0] araddr_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [7:0]        arlen_q;
    logic [CNT_W-1:0]  rcnt_q;
    logic [CNT_W-1:0]  wcnt_q;
    logic [31:0]       rbuf_q [LINE_WORDS];
    logic [31:0]       wbuf_q [LINE_WORDS];
    logic [3:0]        wstrb_q;
    logic              hazard;
    logic              rd_accept;
    logic              wr_accept;
    logic              unused_bits;

    // A refill must not overtake a write-back of the same line, including one being accepted now.
    assign hazard = ((w_state_q != W_IDLE) &&
                     (rd_addr[ADDR_W-1:OFF_W] == awaddr_q[ADDR_W-1:OFF_W])) ||
                    ((w_state_q == W_IDLE) && wr_req &&
                     (rd_addr[ADDR_W-1:OFF_W] == wr_addr[ADDR_W-1:OFF_W]));

    assign rd_accept   = rd_rdy && rd_req;
    assign wr_accept   = wr_rdy && wr_req;
    assign unused_bits = ^{rd_addr[1:0], wr_addr[OFF_W-1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rd_rdy    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        ret_valid = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                rd_rdy = !hazard;
                if (rd_req && !hazard) r_state_d = R_AR;
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) r_state_d = R_DATA;
            end
            R_DATA: begin
                rready = 1'b1;
                if (rvalid && rlast) r_state_d = R_DONE;
            end
            R_DONE: begin
                ret_valid = 1'b1;
                r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        wr_rdy    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        bready    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                wr_rdy = 1'b1;
                if (wr_req) w_state_d = W_AW;
            end
            W_AW: begin
                awvalid = 1'b1;
                if (awready) w_state_d = W_DATA;
            end
            W_DATA: begin
                wvalid = 1'b1;
                wlast  = (wcnt_q == LAST_BEAT);
                if (wready && (wcnt_q == LAST_BEAT)) w_state_d = W_RESP;
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Buffer is zeroed on accept so single-beat returns carry zeros above word 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            araddr_q <= '0;
            arlen_q  <= '0;
            rcnt_q   <= '0;
            for (int i = 0; i < LINE_WORDS; i++) rbuf_q[i] <= '0;
        end else if (rd_accept) begin
            if (rd_type == RD_LINE) begin
                araddr_q <= {rd_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                arlen_q  <= LINE_LEN;
            end else begin
                araddr_q <= {rd_addr[ADDR_W-1:2], 2'b00};
                arlen_q  <= '0;
            end
            rcnt_q <= '0;
            for (int i = 0; i < LINE_WORDS; i++) rbuf_q[i] <= '0;
        end else if (rready && rvalid) begin
            rbuf_q[rcnt_q] <= rdata;
            rcnt_q         <= rcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            awaddr_q <= '0;
            wstrb_q  <= '0;
            wcnt_q   <= '0;
            for (int i = 0; i < LINE_WORDS; i++) wbuf_q[i] <= '0;
        end else if (wr_accept) begin
            awaddr_q <= {wr_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wstrb_q  <= wr_wstrb;
            wcnt_q   <= '0;
            for (int i = 0; i < LINE_WORDS; i++) wbuf_q[i] <= wr_data[i*32 +: 32];
        end else if (wvalid && wready) begin
            wcnt_q <= wcnt_q + CNT_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_ret
            assign ret_data[gi*32 +: 32] = rbuf_q[gi];
        end
    endgenerate

    assign araddr = araddr_q;
    assign arlen  = arlen_q;
    assign awaddr = awaddr_q;
    assign wdata  = wbuf_q[wcnt_q];
    assign wstrb  = wstrb_q;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Bench for dcache_axi_bridge: behavioural AXI slave with a sparse word memory, randomized
// handshake delays, and a line-level model of expected refills and write-back beats.
module tb_dcache_axi_bridge;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rd_req = 1'b0;
    logic [2:0]   rd_type = 3'b000;
    logic [31:0]  rd_addr = '0;
    logic         rd_rdy, ret_valid;
    logic [255:0] ret_data;
    logic         wr_req = 1'b0;
    logic [31:0]  wr_addr = '0;
    logic [3:0]   wr_wstrb = '0;
    logic [255:0] wr_data = '0;
    logic         wr_rdy;
    logic [31:0]  araddr, awaddr, wdata;
    logic [7:0]   arlen;
    logic         arvalid, rready, awvalid, wlast, wvalid, bready;
    logic [3:0]   wstrb;
    logic         arready = 1'b0, rlast = 1'b0, rvalid = 1'b0;
    logic         awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0]  rdata = '0;

    always #5 clk = ~clk;

    dcache_axi_bridge dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_data(ret_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave-side memory; untouched words read as an address hash.
    logic [31:0] mem [int unsigned];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] o;
        o = mem_rd(a);
        for (int b = 0; b < 4; b++) if (s[b]) o[b*8 +: 8] = d[b*8 +: 8];
        mem[a] = o;
    endtask

    function automatic logic [255:0] exp_line(input logic [2:0] t, input logic [31:0] a);
        logic [255:0] r;
        r = '0;
        if (t == 3'b100) begin
            for (int i = 0; i < 8; i++) r[i*32 +: 32] = mem_rd({a[31:5], 5'b0} + 32'(4 * i));
        end else begin
            r[31:0] = mem_rd({a[31:2], 2'b0});
        end
        return r;
    endfunction

    // Slave knobs: negative delay means random per transaction.
    int ar_delay_k = -1;
    int aw_delay_k = -1;
    int b_delay_k  = -1;
    int r_gap_k    = 1;
    int w_mode_k   = 2;   // 0 always ready, 1 toggling, 2 random

    logic [31:0] ar_addr_rec;
    logic [7:0]  ar_len_rec;
    int          ar_hi_rec;
    int          r_beat = 0;
    int          b_done = 0;
    int          b_mark = 0;
    logic [35:0] exp_wq [$];
    logic [31:0] exp_aw [$];

    // Read-side slave: AR acceptance after a chosen delay, then the burst from memory.
    initial begin
        int          ar_hi, ar_lim, r_len;
        bit          r_act, ar_hold;
        logic [31:0] r_base;
        logic [39:0] ar_pay;
        ar_hi = 0; ar_lim = 0; r_len = 0; r_act = 0; ar_hold = 0; r_base = '0; ar_pay = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                arready = 0; rvalid = 0; rlast = 0; rdata = '0;
                r_act = 0; ar_hi = 0; ar_hold = 0; r_beat = 0;
                continue;
            end
            if (r_act) begin
                if (r_gap_k != 0 && $urandom_range(0, 2) == 0) begin
                    rvalid = 0; rlast = 0; rdata = $urandom;
                end else begin
                    rvalid = 1;
                    rdata  = mem_rd(r_base + 32'(4 * r_beat));
                    rlast  = (r_beat == r_len);
                    if (rready) begin
                        r_beat++;
                        if (r_beat > r_len) r_act = 0;
                    end
                end
            end else begin
                rvalid = 0; rlast = 0; rdata = $urandom;
            end
            if (arvalid) begin
                ar_hi++;
                if (ar_hold) chk("ar_stable", {arlen, araddr}, ar_pay);
                if (ar_hi == 1) ar_lim = (ar_delay_k < 0) ? int'($urandom_range(0, 3)) : ar_delay_k;
                if (ar_hi > ar_lim) begin
                    arready = 1;
                    ar_addr_rec = araddr; ar_len_rec = arlen; ar_hi_rec = ar_hi;
                    ar_hi = 0; ar_hold = 0;
                    r_act = 1; r_base = araddr; r_len = int'(arlen); r_beat = 0;
                end else begin
                    arready = 0; ar_hold = 1; ar_pay = {arlen, araddr};
                end
            end else begin
                arready = 0; ar_hi = 0; ar_hold = 0;
            end
        end
    end

    // Write-side slave: AW, W beats checked against the expected queue, then B.
    initial begin
        int          aw_hi, aw_lim, w_beat, b_hi, b_lim;
        bit          w_hold, aw_hold, tog;
        logic [36:0] w_pay;
        logic [35:0] e;
        logic [31:0] aw_pay, w_base;
        aw_hi = 0; aw_lim = 0; w_beat = 0; b_hi = 0; b_lim = 0;
        w_hold = 0; aw_hold = 0; tog = 0; w_pay = '0; e = '0; aw_pay = '0; w_base = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                awready = 0; wready = 0; bvalid = 0;
                aw_hi = 0; b_hi = 0; w_hold = 0; aw_hold = 0; w_beat = 0;
                continue;
            end
            if (bready) begin
                b_hi++;
                if (b_hi == 1) b_lim = (b_delay_k < 0) ? int'($urandom_range(0, 3)) : b_delay_k;
                if (b_hi > b_lim) begin
                    bvalid = 1; b_done++; b_hi = 0;
                end else bvalid = 0;
            end else begin
                bvalid = 0; b_hi = 0;
            end
            if (wvalid) begin
                if (w_hold) chk("w_stable", {wlast, wstrb, wdata}, w_pay);
                case (w_mode_k)
                    0:       wready = 1;
                    1:       begin wready = tog; tog = !tog; end
                    default: wready = 1'($urandom_range(0, 1));
                endcase
                if (wready) begin
                    if (exp_wq.size() > 0) begin
                        e = exp_wq.pop_front();
                        chk("wbeat", {wstrb, wdata}, e);
                    end else chk("w_extra_beat", 1, 0);
                    chk("wlast", wlast, (w_beat == 7));
                    mem_wr(w_base + 32'(4 * w_beat), wdata, wstrb);
                    w_beat++;
                    w_hold = 0;
                end else begin
                    w_hold = 1; w_pay = {wlast, wstrb, wdata};
                end
            end else begin
                wready = 0; w_hold = 0;
            end
            if (awvalid) begin
                aw_hi++;
                if (aw_hold) chk("aw_stable", awaddr, aw_pay);
                if (aw_hi == 1) aw_lim = (aw_delay_k < 0) ? int'($urandom_range(0, 3)) : aw_delay_k;
                if (aw_hi > aw_lim) begin
                    awready = 1;
                    if (exp_aw.size() > 0) chk("awaddr", awaddr, exp_aw.pop_front());
                    else chk("aw_extra", 1, 0);
                    w_base = awaddr; w_beat = 0; aw_hi = 0; aw_hold = 0;
                end else begin
                    awready = 0; aw_hold = 1; aw_pay = awaddr;
                end
            end else begin
                awready = 0; aw_hi = 0; aw_hold = 0;
            end
        end
    end

    task automatic set_read(input logic [2:0] t, input logic [31:0] a);
        rd_req = 1; rd_type = t; rd_addr = a;
    endtask

    task automatic set_write(input logic [31:0] a, input logic [255:0] d, input logic [3:0] s);
        wr_req = 1; wr_addr = a; wr_data = d; wr_wstrb = s;
        b_mark = b_done;
        exp_aw.push_back({a[31:5], 5'b0});
        for (int i = 0; i < 8; i++) exp_wq.push_back({s, d[i*32 +: 32]});
    endtask

    task automatic wait_ret(input logic [255:0] exp);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            rd_req = 0;
            #1;
            if (ret_valid) begin
                seen = 1;
                chk("ret_data", ret_data, exp);
            end
        end
        chk("ret_seen", seen, 1);
        if (seen) begin
            @(negedge clk);
            #1 chk("ret_pulse_one_cycle", ret_valid, 0);
        end
    endtask

    task automatic wait_wr();
        bit done;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            wr_req = 0;
            #1;
            if (b_done > b_mark && wr_rdy) done = 1;
        end
        chk("wr_done", done, 1);
        chk("w_beats_left", exp_wq.size(), 0);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [255:0] e, wd;
        logic [31:0]  ra, wa;
        logic [2:0]   st [3];
        bit           stale, freed;
        int           kind, rl, wl;
        st[0] = 3'b000; st[1] = 3'b001; st[2] = 3'b010;

        #3 reset = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wlast", wlast, 0);
        chk("rst_bready", bready, 0);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_ret_data", ret_data, 0);
        chk("rst_rd_rdy", rd_rdy, 1);
        chk("rst_wr_rdy", wr_rdy, 1);
        @(negedge clk);
        reset = 1;

        // Line refill, zero-wait slave.
        for (int i = 0; i < 8; i++) mem[32'h1C00_0120 + 32'(4 * i)] = 32'(32'h11 * (i + 1));
        ar_delay_k = 0; r_gap_k = 0;
        e = exp_line(3'b100, 32'h1C00_0124);
        @(negedge clk); set_read(3'b100, 32'h1C00_0124);
        #1 chk("rd_rdy_issue", rd_rdy, 1);
        wait_ret(e);
        chk("t1_araddr", ar_addr_rec, 32'h1C00_0120);
        chk("t1_arlen", ar_len_rec, 7);
        chk("t1_word0", ret_data[31:0], 32'h11);
        chk("t1_word7", ret_data[255:224], 32'h88);

        // Single-word read with arready held off for 4 cycles.
        ar_delay_k = 4;
        e = exp_line(3'b010, 32'hBFAF_8004);
        @(negedge clk); set_read(3'b010, 32'hBFAF_8004);
        #1 chk("rd_rdy_issue", rd_rdy, 1);
        wait_ret(e);
        chk("t2_arvalid_cycles", ar_hi_rec, 5);
        chk("t2_araddr", ar_addr_rec, 32'hBFAF_8004);
        chk("t2_arlen", ar_len_rec, 0);
        chk("t2_upper_zero", ret_data[255:32], 0);

        // Write-back with wready toggling.
        ar_delay_k = 0; aw_delay_k = 0; b_delay_k = 2; w_mode_k = 1;
        for (int i = 0; i < 8; i++) wd[i*32 +: 32] = 32'(32'hA0 + i);
        @(negedge clk); set_write(32'h0000_1040, wd, 4'hF);
        #1 chk("wr_rdy_issue", wr_rdy, 1);
        wait_wr();
        chk("t3_wr_rdy", wr_rdy, 1);

        // Same-line hazard while a slow write-back is pending; other line passes.
        aw_delay_k = 8; b_delay_k = 3;
        @(negedge clk); set_write(32'h0000_2000, rand_line(), 4'hF);
        #1 chk("wr_rdy_issue", wr_rdy, 1);
        @(negedge clk); wr_req = 0; set_read(3'b100, 32'h0000_2010);
        #1 chk("hazard_same_line", rd_rdy, 0);
        repeat (3) begin
            @(negedge clk);
            #1 chk("hazard_hold", rd_rdy, 0);
        end
        @(negedge clk); rd_addr = 32'h0000_3000;
        e = exp_line(3'b100, 32'h0000_3000);
        #1 chk("hazard_other_line", rd_rdy, 1);
        wait_ret(e);
        @(negedge clk); set_read(3'b100, 32'h0000_2010);
        #1 chk("hazard_write_still_busy", wr_rdy, 0);
        freed = 0;
        for (int i = 0; i < 100 && !freed; i++) begin
            if (wr_rdy) freed = 1;
            else begin
                chk("hazard_wait", rd_rdy, 0);
                @(negedge clk);
                #1;
            end
        end
        chk("hazard_write_freed", freed, 1);
        chk("hazard_release", rd_rdy, 1);
        chk("w_beats_left", exp_wq.size(), 0);
        e = exp_line(3'b100, 32'h0000_2010);
        wait_ret(e);

        // Same line requested in the write acceptance cycle is blocked.
        aw_delay_k = -1; b_delay_k = -1;
        @(negedge clk); set_write(32'h0000_5000, rand_line(), 4'h5);
        set_read(3'b100, 32'h0000_501C);
        #1 chk("hazard_accept_cycle", rd_rdy, 0);
        chk("wr_rdy_issue", wr_rdy, 1);
        rd_req = 0;
        wait_wr();

        // Reset in the middle of a refill burst.
        ar_delay_k = 0; r_gap_k = 0;
        @(negedge clk); set_read(3'b100, 32'h6000_0040);
        #1 chk("rd_rdy_issue", rd_rdy, 1);
        freed = 0;
        for (int i = 0; i < 50 && !freed; i++) begin
            @(negedge clk);
            rd_req = 0;
            if (r_beat == 4) freed = 1;
        end
        chk("midburst_reached", freed, 1);
        #1 chk("pre_reset_rready", rready, 1);
        #1 reset = 0;
        #1;
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_ret_valid", ret_valid, 0);
        chk("mid_rst_rd_rdy", rd_rdy, 1);
        repeat (2) @(negedge clk);
        reset = 1;
        stale = 0;
        repeat (15) begin
            @(negedge clk);
            #1 if (ret_valid) stale = 1;
        end
        chk("no_stale_ret", stale, 0);
        chk("post_rst_rd_rdy", rd_rdy, 1);

        // Randomized mix of refills, single reads, write-backs and concurrent pairs.
        ar_delay_k = -1; aw_delay_k = -1; b_delay_k = -1; r_gap_k = 1; w_mode_k = 2;
        for (int it = 0; it < 30; it++) begin
            kind = int'($urandom_range(0, 3));
            rl = int'($urandom_range(0, 15));
            wl = int'($urandom_range(0, 15));
            if (wl == rl) wl = (rl + 1) % 16;
            ra = 32'h4000_0000 | (32'(rl) << 5) | ($urandom & 32'h1F);
            wa = 32'h4000_0000 | (32'(wl) << 5) | ($urandom & 32'h1F);
            wd = rand_line();
            case (kind)
                0: begin
                    e = exp_line(3'b100, ra);
                    @(negedge clk); set_read(3'b100, ra);
                    #1 chk("rd_rdy_issue", rd_rdy, 1);
                    wait_ret(e);
                end
                1: begin
                    rd_type = st[$urandom_range(0, 2)];
                    e = exp_line(rd_type, ra);
                    @(negedge clk); set_read(rd_type, ra);
                    #1 chk("rd_rdy_issue", rd_rdy, 1);
                    wait_ret(e);
                end
                2: begin
                    @(negedge clk); set_write(wa, wd, 4'($urandom_range(1, 15)));
                    #1 chk("wr_rdy_issue", wr_rdy, 1);
                    wait_wr();
                end
                default: begin
                    e = exp_line(3'b100, ra);
                    @(negedge clk);
                    set_read(3'b100, ra);
                    set_write(wa, wd, 4'($urandom_range(1, 15)));
                    #1;
                    chk("both_rd_rdy", rd_rdy, 1);
                    chk("both_wr_rdy", wr_rdy, 1);
                    fork
                        wait_ret(e);
                        wait_wr();
                    join
                end
            endcase
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
